// File: rtl/gpu_pkg.sv
// Shared definitions for the blob sprite configuration path: field codes,
// the per-blob configuration record and the commit controller state type.
package gpu_pkg;

    localparam int CFG_ADDR_W = 16;

    localparam logic [2:0] FLD_EN      = 3'd0;
    localparam logic [2:0] FLD_X1      = 3'd1;
    localparam logic [2:0] FLD_Y1      = 3'd2;
    localparam logic [2:0] FLD_X2      = 3'd3;
    localparam logic [2:0] FLD_Y2      = 3'd4;
    localparam logic [2:0] FLD_ADDR    = 3'd5;
    localparam logic [2:0] FLD_LAYER   = 3'd6;
    localparam logic [2:0] FLD_ILLEGAL = 3'd7;

    typedef struct packed {
        logic                  enable;
        logic [9:0]            x1;
        logic [9:0]            y1;
        logic [9:0]            x2;
        logic [9:0]            y2;
        logic [CFG_ADDR_W-1:0] address;
        logic [1:0]            layer;
    } blob_cfg_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_COPY    = 2'd2
    } cfg_state_t;

endpackage

// File: rtl/blob_cfg_bank.sv
// Register array of per-blob configuration records with a single-field write
// port, a whole-entry write port and an indexed whole-entry read port.
module blob_cfg_bank
    import gpu_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  field_we,
    input  logic [IDX_W-1:0]      field_idx,
    input  logic [2:0]            field_sel,
    input  logic [CFG_ADDR_W-1:0] field_data,
    input  logic                  entry_we,
    input  logic [IDX_W-1:0]      entry_idx,
    input  blob_cfg_t             entry_in,
    input  logic [IDX_W-1:0]      rd_idx,
    output blob_cfg_t             rd_entry,
    output blob_cfg_t [N-1:0]     entries
);

    blob_cfg_t [N-1:0] mem;

    // A whole-entry write takes priority; the controller never issues both at once.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                mem[i] <= '0;
            end else if (entry_we && entry_idx == IDX_W'(i)) begin
                mem[i] <= entry_in;
            end else if (field_we && field_idx == IDX_W'(i)) begin
                case (field_sel)
                    FLD_EN:    mem[i].enable  <= field_data[0];
                    FLD_X1:    mem[i].x1      <= field_data[9:0];
                    FLD_Y1:    mem[i].y1      <= field_data[9:0];
                    FLD_X2:    mem[i].x2      <= field_data[9:0];
                    FLD_Y2:    mem[i].y2      <= field_data[9:0];
                    FLD_ADDR:  mem[i].address <= field_data;
                    FLD_LAYER: mem[i].layer   <= field_data[1:0];
                    default:   ;
                endcase
            end
        end
    end

    assign rd_entry = mem[rd_idx];
    assign entries  = mem;

endmodule

// File: rtl/blob_config_ctrl.sv
// Shadow/active configuration controller for the blob sprite engines; the
// shadow bank is copied to the active bank one blob per cycle at frame end.
module blob_config_ctrl
    import gpu_pkg::*;
#(
    parameter int NR_OF_BLOBS   = 4,
    parameter int ram_add_width = 16,
    parameter int H_ACTIVE      = 640,
    parameter int V_ACTIVE      = 480,
    localparam int BLOB_W       = (NR_OF_BLOBS > 1) ? $clog2(NR_OF_BLOBS) : 1
)(
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      clk25en,
    input  logic [9:0]                                curr_x_pos,
    input  logic [9:0]                                curr_y_pos,
    input  logic                                      cfg_valid,
    output logic                                      cfg_ready,
    input  logic [BLOB_W-1:0]                         cfg_blob,
    input  logic [2:0]                                cfg_field,
    input  logic [ram_add_width-1:0]                  cfg_data,
    input  logic                                      commit_req,
    output logic                                      commit_pending,
    output logic                                      commit_done,
    output logic                                      cfg_err,
    output logic [NR_OF_BLOBS-1:0]                    sprite_enable,
    output logic [NR_OF_BLOBS-1:0][9:0]               x1_pos,
    output logic [NR_OF_BLOBS-1:0][9:0]               y1_pos,
    output logic [NR_OF_BLOBS-1:0][9:0]               x2_pos,
    output logic [NR_OF_BLOBS-1:0][9:0]               y2_pos,
    output logic [NR_OF_BLOBS-1:0][ram_add_width-1:0] address_out,
    output logic [NR_OF_BLOBS-1:0][1:0]               layer_out
);

    cfg_state_t                    state, next_state;
    logic [BLOB_W-1:0]             copy_idx, next_idx;
    logic                          fe, wr_fire, wr_legal, copy_we, copy_last;
    blob_cfg_t                     copy_entry;
    blob_cfg_t                     active_rd_unused;
    blob_cfg_t [NR_OF_BLOBS-1:0]   active_all, shadow_all_unused;

    assign fe = clk25en
             && curr_x_pos == 10'(H_ACTIVE - 1)
             && curr_y_pos == 10'(V_ACTIVE - 1);

    // Out-of-range blob indices and field code 7 are accepted but dropped.
    assign wr_fire   = cfg_valid && cfg_ready;
    assign wr_legal  = (cfg_field != FLD_ILLEGAL) && (32'(cfg_blob) < NR_OF_BLOBS);
    assign copy_we   = (state == ST_COPY);
    assign copy_last = (copy_idx == BLOB_W'(NR_OF_BLOBS - 1));

    always_comb begin
        next_state     = state;
        next_idx       = copy_idx;
        cfg_ready      = 1'b0;
        commit_pending = 1'b0;
        case (state)
            ST_IDLE: begin
                cfg_ready = !reset;
                if (commit_req) next_state = ST_PENDING;
            end
            ST_PENDING: begin
                commit_pending = 1'b1;
                if (fe) begin
                    next_state = ST_COPY;
                    next_idx   = '0;
                end
            end
            ST_COPY: begin
                if (copy_last) next_state = ST_IDLE;
                else           next_idx   = copy_idx + 1'b1;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            copy_idx    <= '0;
            commit_done <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            state       <= next_state;
            copy_idx    <= next_idx;
            commit_done <= copy_we && copy_last;
            cfg_err     <= wr_fire && !wr_legal;
        end
    end

    blob_cfg_bank #(.N(NR_OF_BLOBS), .IDX_W(BLOB_W)) u_shadow (
        .clk        (clk),
        .reset      (reset),
        .field_we   (wr_fire && wr_legal),
        .field_idx  (cfg_blob),
        .field_sel  (cfg_field),
        .field_data (cfg_data),
        .entry_we   (1'b0),
        .entry_idx  ('0),
        .entry_in   ('0),
        .rd_idx     (copy_idx),
        .rd_entry   (copy_entry),
        .entries    (shadow_all_unused)
    );

    blob_cfg_bank #(.N(NR_OF_BLOBS), .IDX_W(BLOB_W)) u_active (
        .clk        (clk),
        .reset      (reset),
        .field_we   (1'b0),
        .field_idx  ('0),
        .field_sel  (3'd0),
        .field_data ('0),
        .entry_we   (copy_we),
        .entry_idx  (copy_idx),
        .entry_in   (copy_entry),
        .rd_idx     ('0),
        .rd_entry   (active_rd_unused),
        .entries    (active_all)
    );

    for (genvar i = 0; i < NR_OF_BLOBS; i++) begin : g_out
        assign sprite_enable[i] = active_all[i].enable;
        assign x1_pos[i]        = active_all[i].x1;
        assign y1_pos[i]        = active_all[i].y1;
        assign x2_pos[i]        = active_all[i].x2;
        assign y2_pos[i]        = active_all[i].y2;
        assign address_out[i]   = active_all[i].address;
        assign layer_out[i]     = active_all[i].layer;
    end

endmodule

// File: tb/tb_blob_config_ctrl.sv
// Randomized and directed bench for blob_config_ctrl against a per-field
// shadow/active array model driven by the frame-end commit rules.
module tb_blob_config_ctrl;

    localparam int NB = 5;
    localparam int AW = 16;
    localparam int HA = 16;
    localparam int VA = 30;
    localparam int BW = 3;
    localparam int FRAME_CYCLES = 2 * HA * VA;

    logic clk = 1'b0;
    logic reset;
    logic clk25en;
    logic [9:0] curr_x_pos, curr_y_pos;
    logic cfg_valid, cfg_ready;
    logic [BW-1:0] cfg_blob;
    logic [2:0] cfg_field;
    logic [AW-1:0] cfg_data;
    logic commit_req, commit_pending, commit_done, cfg_err;
    logic [NB-1:0] sprite_enable;
    logic [NB-1:0][9:0] x1_pos, y1_pos, x2_pos, y2_pos;
    logic [NB-1:0][AW-1:0] address_out;
    logic [NB-1:0][1:0] layer_out;

    blob_config_ctrl #(
        .NR_OF_BLOBS(NB), .ram_add_width(AW), .H_ACTIVE(HA), .V_ACTIVE(VA)
    ) dut (
        .clk(clk), .reset(reset), .clk25en(clk25en),
        .curr_x_pos(curr_x_pos), .curr_y_pos(curr_y_pos),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_blob(cfg_blob),
        .cfg_field(cfg_field), .cfg_data(cfg_data), .commit_req(commit_req),
        .commit_pending(commit_pending), .commit_done(commit_done), .cfg_err(cfg_err),
        .sprite_enable(sprite_enable), .x1_pos(x1_pos), .y1_pos(y1_pos),
        .x2_pos(x2_pos), .y2_pos(y2_pos), .address_out(address_out), .layer_out(layer_out)
    );

    always #5 clk = ~clk;

    // Model: field values per blob, index 0..6 = enable,x1,y1,x2,y2,address,layer.
    int m_sh [NB][7];
    int m_ac [NB][7];
    bit armed;
    int fe_cyc;
    int cyc;
    bit exp_done, exp_err, last_accept;
    int checks, errors;

    function automatic int fwidth(input int f);
        case (f)
            0: return 1;
            5: return AW;
            6: return 2;
            default: return 10;
        endcase
    endfunction

    function automatic logic [127:0] pack_active(input int f);
        logic [127:0] r, v;
        r = '0;
        for (int i = 0; i < NB; i++) begin
            v = 128'(unsigned'(m_ac[i][f]));
            r = r | (v << (i * fwidth(f)));
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: check readiness, predict the edge, then check every output after it.
    task automatic step();
        bit fe_now, pre_idle, pre_armed;
        int pre_fe, k, b, f;
        #1;
        pre_idle = !armed && fe_cyc < 0;
        checkOutput("cfg_ready", 128'(cfg_ready), 128'(!reset && pre_idle));
        fe_now = clk25en && curr_x_pos == 10'(HA - 1) && curr_y_pos == 10'(VA - 1);
        last_accept = 0;
        exp_done = 0;
        exp_err = 0;
        if (reset) begin
            for (int i = 0; i < NB; i++)
                for (int j = 0; j < 7; j++) begin
                    m_sh[i][j] = 0;
                    m_ac[i][j] = 0;
                end
            armed = 0;
            fe_cyc = -1;
        end else begin
            pre_armed = armed;
            pre_fe = fe_cyc;
            if (cfg_valid && pre_idle) begin
                last_accept = 1;
                b = int'(cfg_blob);
                f = int'(cfg_field);
                if (f == 7 || b >= NB) exp_err = 1;
                else m_sh[b][f] = int'(cfg_data) & ((1 << fwidth(f)) - 1);
            end
            if (pre_fe >= 0) begin
                k = cyc - pre_fe - 1;
                for (int j = 0; j < 7; j++) m_ac[k][j] = m_sh[k][j];
                if (k == NB - 1) begin
                    exp_done = 1;
                    fe_cyc = -1;
                end
            end
            if (pre_idle && commit_req) armed = 1;
            else if (pre_armed && fe_now) begin
                armed = 0;
                fe_cyc = cyc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        checkOutput("commit_done", 128'(commit_done), 128'(exp_done));
        checkOutput("cfg_err", 128'(cfg_err), 128'(exp_err));
        checkOutput("commit_pending", 128'(commit_pending), 128'(armed));
        checkOutput("sprite_enable", 128'(sprite_enable), pack_active(0));
        checkOutput("x1_pos", 128'(x1_pos), pack_active(1));
        checkOutput("y1_pos", 128'(y1_pos), pack_active(2));
        checkOutput("x2_pos", 128'(x2_pos), pack_active(3));
        checkOutput("y2_pos", 128'(y2_pos), pack_active(4));
        checkOutput("address_out", 128'(address_out), pack_active(5));
        checkOutput("layer_out", 128'(layer_out), pack_active(6));
        if (clk25en) begin
            if (curr_x_pos == 10'(HA - 1)) begin
                curr_x_pos = '0;
                curr_y_pos = (curr_y_pos == 10'(VA - 1)) ? 10'd0 : curr_y_pos + 10'd1;
            end else begin
                curr_x_pos = curr_x_pos + 10'd1;
            end
        end
        clk25en = !clk25en;
    endtask

    task automatic applyStimulus(input int b, input int f, input int d);
        bit done_ok;
        cfg_valid = 1'b1;
        cfg_blob = BW'(b);
        cfg_field = 3'(f);
        cfg_data = AW'(d);
        done_ok = 0;
        for (int n = 0; n < 3000 && !done_ok; n++) begin
            step();
            done_ok = last_accept;
        end
        cfg_valid = 1'b0;
        if (!done_ok) checkOutput("write_timeout", 128'(0), 128'(1));
    endtask

    task automatic pulseCommit();
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
    endtask

    task automatic waitDone(output int n_steps);
        bit seen;
        seen = 0;
        n_steps = 0;
        for (int n = 0; n < 3000 && !seen; n++) begin
            step();
            n_steps++;
            seen = exp_done;
        end
        if (!seen) checkOutput("done_timeout", 128'(0), 128'(1));
    endtask

    task automatic waitFeNext();
        bit hit;
        hit = 0;
        for (int n = 0; n < 3000 && !hit; n++) begin
            hit = clk25en && curr_x_pos == 10'(HA - 1) && curr_y_pos == 10'(VA - 1);
            if (!hit) step();
        end
        if (!hit) checkOutput("fe_timeout", 128'(0), 128'(1));
    endtask

    initial begin
        int n;
        checks = 0; errors = 0; cyc = 0; fe_cyc = -1; armed = 0;
        reset = 1'b1; clk25en = 1'b0; curr_x_pos = '0; curr_y_pos = '0;
        cfg_valid = 1'b1; cfg_blob = '0; cfg_field = 3'd1; cfg_data = 16'h0123;
        commit_req = 1'b0;

        for (int i = 0; i < 5; i++) step();
        reset = 1'b0;
        cfg_valid = 1'b0;
        step();
        checkOutput("reset_ready", 128'(cfg_ready), 128'(1));

        // Basic commit on blob 0
        applyStimulus(0, 1, 3);
        applyStimulus(0, 2, 5);
        applyStimulus(0, 3, 6);
        applyStimulus(0, 4, 7);
        applyStimulus(0, 5, 50);
        applyStimulus(0, 6, 3);
        applyStimulus(0, 0, 1);
        pulseCommit();
        waitFeNext();
        step();
        waitDone(n);
        checkOutput("basic_latency", 128'(n), 128'(NB));
        checkOutput("basic_x1", 128'(x1_pos[0]), 128'(3));
        checkOutput("basic_y2", 128'(y2_pos[0]), 128'(7));
        checkOutput("basic_addr", 128'(address_out[0]), 128'(50));
        checkOutput("basic_en", 128'(sprite_enable[0]), 128'(1));

        // Write stalls while a commit is pending
        pulseCommit();
        applyStimulus(2, 5, 100);
        checkOutput("stall_not_yet", 128'(address_out[2]), 128'(0));
        pulseCommit();
        waitDone(n);
        checkOutput("stall_addr", 128'(address_out[2]), 128'(100));

        // commit_req coincident with frame end waits a full frame
        waitFeNext();
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        waitDone(n);
        checkOutput("coinc_latency", 128'(n), 128'(FRAME_CYCLES + NB));

        // Write together with commit_req is included
        cfg_valid = 1'b1; cfg_blob = 3'd3; cfg_field = 3'd1; cfg_data = 16'd77;
        commit_req = 1'b1;
        step();
        cfg_valid = 1'b0; commit_req = 1'b0;
        waitDone(n);
        checkOutput("same_cycle_x1", 128'(x1_pos[3]), 128'(77));

        // Illegal field and blob index
        applyStimulus(1, 7, 16'h3ff);
        checkOutput("err_field7", 128'(cfg_err), 128'(1));
        applyStimulus(5, 1, 16'h155);
        checkOutput("err_blob5", 128'(cfg_err), 128'(1));
        pulseCommit();
        waitDone(n);
        checkOutput("illegal_x1_b1", 128'(x1_pos[1]), 128'(0));

        // Reset two cycles into the copy
        applyStimulus(1, 2, 9);
        pulseCommit();
        waitFeNext();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) step();
        checkOutput("rst_copy_x1_b0", 128'(x1_pos[0]), 128'(0));
        checkOutput("rst_copy_ready", 128'(cfg_ready), 128'(1));

        // Random traffic
        for (int i = 0; i < 6000; i++) begin
            cfg_valid = ($urandom_range(0, 1) == 1);
            cfg_blob = BW'($urandom_range(0, 7));
            cfg_field = 3'($urandom_range(0, 7));
            cfg_data = AW'($urandom);
            commit_req = ($urandom_range(0, 99) == 0);
            step();
        end
        cfg_valid = 1'b0;
        commit_req = 1'b0;
        pulseCommit();
        waitDone(n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
